layer_compositor: RTL and testbench

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

---
 rtl/layer_compositor_pkg.sv | 27 ++
 rtl/layer_compositor_if.sv | 27 ++
 rtl/layer_compositor_prio_enc.sv | 24 ++
 rtl/layer_compositor.sv | 143 ++++++++++++++
 tb/tb_layer_compositor.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/layer_compositor_pkg.sv
// Shared game definitions: game-state codes, the compositor FSM encoding and
// a helper used to size layer indices.
package layer_compositor_pkg;

  typedef enum logic [3:0] {
    TITLE     = 4'd0,
    MENU      = 4'd1,
    PLAY      = 4'd2,
    PAUSE     = 4'd3,
    SHOP      = 4'd4,
    BOSS      = 4'd5,
    VICTORY   = 4'd6,
    GAME_OVER = 4'd7,
    FAIL      = 4'd8
  } game_state_e;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } comp_fsm_e;

  // A single layer still needs a 1-bit index field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// Layer-source / pixel-sink bundle of the compositor. The master side supplies
// layer addresses and hits; the slave (compositor) returns the composited pixel.
interface layer_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int ADDR_W     = 17
);
  import layer_compositor_pkg::*;

  localparam int ID_W = id_width(NUM_LAYERS);

  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr;
  logic [NUM_LAYERS-1:0]        layer_hit;
  logic [ADDR_W-1:0]            pixel_addr;
  logic                         not_blank;
  logic [ID_W-1:0]              layer_id;
  logic                         in_transition;

  modport master (
    output layer_addr, layer_hit,
    input  pixel_addr, not_blank, layer_id, in_transition
  );

  modport slave (
    input  layer_addr, layer_hit,
    output pixel_addr, not_blank, layer_id, in_transition
  );
endinterface

// File: rtl/layer_compositor_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
module prio_enc
  import layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS = 4
) (
  input  logic [NUM_LAYERS-1:0]           req,
  output logic                            valid,
  output logic [id_width(NUM_LAYERS)-1:0] idx
);
  localparam int ID_W = id_width(NUM_LAYERS);

  // Scanning downwards lets the lowest index overwrite any higher one.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end
endmodule

// File: rtl/layer_compositor.sv
// Sprite/background layer compositor with a blanking transition on game-state
// changes and per-layer blinking. Two-cycle registered pixel output.
//
// state | meaning
// SHOW  | layers drawn according to the latched game state
// BLANK | output forced blank for trans_cnt frame ends after a state change
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int ADDR_W       = 17,
  parameter int STATE_W      = 4,
  parameter int NUM_STATES   = 9,
  parameter int H_LAST       = 799,
  parameter int V_LAST       = 524,
  parameter int TRANS_FRAMES = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [STATE_W-1:0]             state,
  input  logic [9:0]                     h_cnt,
  input  logic [9:0]                     v_cnt,
  input  logic [NUM_STATES*NUM_LAYERS-1:0] state_mask,
  input  logic [NUM_LAYERS-1:0]          blink_mask,
  layer_compositor_if.slave              bus
);
  localparam int ID_W = id_width(NUM_LAYERS);
  localparam int TC_W = $clog2(TRANS_FRAMES + 1);
  localparam int BC_W = $clog2(BLINK_FRAMES + 1);

  comp_fsm_e                    fsm_q, fsm_d;
  logic [STATE_W-1:0]           latched_q, latched_d;
  logic [TC_W-1:0]              trans_q, trans_d;
  logic [BC_W-1:0]              blink_cnt;
  logic                         blink_phase;
  logic                         frame_end, state_chg;
  logic [NUM_LAYERS-1:0]        en_mask, elig, elig_q;
  logic [NUM_LAYERS*ADDR_W-1:0] addr_q;
  logic                         blank_q;
  logic                         enc_valid;
  logic [ID_W-1:0]              enc_idx;
  logic [ADDR_W-1:0]            sel_addr;

  assign frame_end = (h_cnt == 10'(H_LAST)) && (v_cnt == 10'(V_LAST));
  assign state_chg = (state != latched_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= SHOW;
      latched_q <= '0;
      trans_q   <= '0;
    end else begin
      fsm_q     <= fsm_d;
      latched_q <= latched_d;
      trans_q   <= trans_d;
    end
  end

  // A state change outranks the final frame end, so a late change restarts the blank.
  always_comb begin
    fsm_d     = fsm_q;
    latched_d = latched_q;
    trans_d   = trans_q;
    if (state_chg) begin
      fsm_d     = BLANK;
      latched_d = state;
      trans_d   = TC_W'(TRANS_FRAMES);
    end else if (fsm_q == BLANK && frame_end) begin
      trans_d = trans_q - 1'b1;
      if (trans_q == TC_W'(1)) fsm_d = SHOW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Out-of-range state codes match no entry and leave every layer disabled.
  always_comb begin
    en_mask = '0;
    for (int s = 0; s < NUM_STATES; s++) begin
      if (latched_q == STATE_W'(s)) en_mask = state_mask[s*NUM_LAYERS +: NUM_LAYERS];
    end
  end

  assign elig = bus.layer_hit & en_mask & ~(blink_mask & {NUM_LAYERS{blink_phase}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elig_q  <= '0;
      addr_q  <= '0;
      blank_q <= 1'b0;
    end else begin
      elig_q  <= elig;
      addr_q  <= bus.layer_addr;
      blank_q <= (fsm_q == BLANK);
    end
  end

  prio_enc #(.NUM_LAYERS(NUM_LAYERS)) u_prio_enc (
    .req   (elig_q),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (enc_idx == ID_W'(i)) sel_addr = addr_q[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pixel_addr    <= '0;
      bus.not_blank     <= 1'b0;
      bus.layer_id      <= '0;
      bus.in_transition <= 1'b0;
    end else begin
      bus.in_transition <= blank_q;
      if (blank_q || !enc_valid) begin
        bus.pixel_addr <= '0;
        bus.not_blank  <= 1'b0;
        bus.layer_id   <= '0;
      end else begin
        bus.pixel_addr <= sel_addr;
        bus.not_blank  <= 1'b1;
        bus.layer_id   <= enc_idx;
      end
    end
  end
endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor on a shrunken 8x4 frame with short
// transition and blink periods.
module tb_layer_compositor;
  import layer_compositor_pkg::*;

  localparam int NL = 4;
  localparam int AW = 17;
  localparam int SW = 4;
  localparam int NS = 9;
  localparam int HL = 7;
  localparam int VL = 3;
  localparam int TF = 2;
  localparam int BF = 2;

  localparam logic [AW-1:0] A0 = 17'h00A11;
  localparam logic [AW-1:0] A1 = 17'h00B22;
  localparam logic [AW-1:0] A2 = 17'h11C33;
  localparam logic [AW-1:0] A3 = 17'h00D44;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [SW-1:0]     state;
  logic [9:0]        h_cnt, v_cnt;
  logic [NS*NL-1:0]  state_mask;
  logic [NL-1:0]     blink_mask;

  int checks   = 0;
  int failures = 0;
  int fe_count = 0;

  layer_compositor_if #(.NUM_LAYERS(NL), .ADDR_W(AW)) bus ();

  layer_compositor #(
    .NUM_LAYERS(NL), .ADDR_W(AW), .STATE_W(SW), .NUM_STATES(NS),
    .H_LAST(HL), .V_LAST(VL), .TRANS_FRAMES(TF), .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .state_mask (state_mask),
    .blink_mask (blink_mask),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_px(input string tag, input logic nb, input int id,
                           input logic [AW-1:0] addr, input logic tr);
    check_val({tag, ".not_blank"},     32'(bus.not_blank),     32'(nb));
    check_val({tag, ".layer_id"},      32'(bus.layer_id),      32'(id));
    check_val({tag, ".pixel_addr"},    32'(bus.pixel_addr),    32'(addr));
    check_val({tag, ".in_transition"}, 32'(bus.in_transition), 32'(tr));
  endtask

  // One clock; the scan counters move #1 after the edge, mimicking a VGA timer.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      if (!rst && h_cnt == 10'(HL) && v_cnt == 10'(VL)) fe_count++;
      @(posedge clk);
      #1;
      if (h_cnt == 10'(HL)) begin
        h_cnt = '0;
        v_cnt = (v_cnt == 10'(VL)) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt = h_cnt + 10'd1;
      end
    end
  endtask

  task automatic goto_pos(input int h, input int v);
    int n = 0;
    while (!(h_cnt == 10'(h) && v_cnt == 10'(v)) && n < 200) begin
      step(1);
      n++;
    end
    if (n >= 200) begin
      failures++;
      $display("FAIL goto_pos: position %0d,%0d not reached", h, v);
    end
  endtask

  // Wait out a full blank: two frame ends, then the 3-cycle FSM-to-output delay.
  task automatic ride_out_blank();
    goto_pos(HL, VL);
    step(1);
    goto_pos(HL, VL);
    step(3);
  endtask

  initial begin
    state          = SW'(TITLE);
    h_cnt          = '0;
    v_cnt          = '0;
    blink_mask     = '0;
    bus.layer_hit  = '0;
    bus.layer_addr = {A3, A2, A1, A0};
    state_mask     = '0;
    state_mask[0*NL +: NL] = 4'b0101;
    state_mask[1*NL +: NL] = 4'b1111;
    state_mask[2*NL +: NL] = 4'b0010;
    state_mask[8*NL +: NL] = 4'b1000;

    #1 rst = 1'b1;
    #2 expect_px("reset", 1'b0, 0, '0, 1'b0);
    step(2);
    rst = 1'b0;

    // Priority and two-cycle latency in state 0 (layers 0 and 2 enabled).
    bus.layer_hit = 4'b0101;
    step(1);
    check_val("latency1.not_blank", 32'(bus.not_blank), 32'(0));
    step(1);
    expect_px("hit0101", 1'b1, 0, A0, 1'b0);
    bus.layer_hit = 4'b0100;
    step(2);
    expect_px("hit0100", 1'b1, 2, A2, 1'b0);
    bus.layer_hit = 4'b1010;
    step(2);
    expect_px("hit1010", 1'b0, 0, '0, 1'b0);
    bus.layer_hit = 4'b1111;
    step(2);
    expect_px("hit1111", 1'b1, 0, A0, 1'b0);

    // Change 0 -> 2 mid-frame: blank for the rest of it plus one whole frame.
    bus.layer_hit = 4'b0111;
    goto_pos(2, 1);
    state = SW'(PLAY);
    step(2);
    expect_px("chg_edge", 1'b1, 0, A0, 1'b0);
    step(1);
    expect_px("chg_blank", 1'b0, 0, '0, 1'b1);
    goto_pos(HL, VL);
    step(1);
    goto_pos(3, 1);
    expect_px("blank_frame2", 1'b0, 0, '0, 1'b1);
    goto_pos(HL, VL);
    step(2);
    expect_px("blank_last", 1'b0, 0, '0, 1'b1);
    step(1);
    expect_px("show_state2", 1'b1, 1, A1, 1'b0);

    // Second change one frame into the blank restarts the full count.
    state = SW'(TITLE);
    goto_pos(HL, VL);
    step(1);
    goto_pos(4, 1);
    state = SW'(MENU);
    step(1);
    goto_pos(HL, VL);
    step(1);
    goto_pos(HL, VL);
    expect_px("restart_hold", 1'b0, 0, '0, 1'b1);
    step(3);
    expect_px("restart_show", 1'b1, 0, A0, 1'b0);

    // Change arriving exactly on the final frame end keeps the blank going.
    state = SW'(PLAY);
    step(1);
    goto_pos(HL, VL);
    step(1);
    goto_pos(HL, VL);
    state = SW'(TITLE);
    step(3);
    expect_px("coincide_hold", 1'b0, 0, '0, 1'b1);
    ride_out_blank();
    expect_px("coincide_show", 1'b1, 0, A0, 1'b0);

    // Undefined state code disables every layer.
    state = 4'd12;
    bus.layer_hit = 4'b1111;
    step(1);
    ride_out_blank();
    expect_px("state12_all", 1'b0, 0, '0, 1'b0);
    bus.layer_hit = 4'b0001;
    step(2);
    expect_px("state12_one", 1'b0, 0, '0, 1'b0);

    // Reset in the middle of a blank aborts it and returns to state 0.
    state = SW'(PLAY);
    step(4);
    check_val("pre_rst.in_transition", 32'(bus.in_transition), 32'(1));
    #2 rst = 1'b1;
    state = SW'(TITLE);
    bus.layer_hit = 4'b0101;
    #1 expect_px("rst_mid", 1'b0, 0, '0, 1'b0);
    step(1);
    rst = 1'b0;
    fe_count = 0;
    step(2);
    expect_px("post_rst", 1'b1, 0, A0, 1'b0);

    // Blinking layer 1: visible in phase 0, hidden in phase 1, BF frames each.
    state = SW'(MENU);
    bus.layer_hit = 4'b0010;
    blink_mask = 4'b0010;
    step(1);
    ride_out_blank();
    for (int f = 0; f < 6; f++) begin
      goto_pos(3, 2);
      check_val($sformatf("blink_f%0d.not_blank", f), 32'(bus.not_blank),
                32'(((fe_count / BF) % 2) == 0));
      step(1);
    end
    blink_mask = '0;
    step(2);
    goto_pos(3, 2);
    expect_px("no_blink", 1'b1, 1, A1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
